// File: rtl/swarm_pkg.sv
// rtl/swarm_pkg.sv - shared task, queue and register-map types for the task enqueue path
package swarm;

    localparam int LOG_TQ_SIZE = 4;
    localparam int REG_ADDR_W  = 8;
    localparam int REG_DATA_W  = 32;

    typedef logic [LOG_TQ_SIZE-1:0] tq_slot_t;
    typedef logic [7:0]             epoch_t;
    typedef logic [3:0]             tile_id_t;
    typedef logic [4:0]             tsb_entry_id_t;

    typedef struct packed {
        logic [31:0] ts;
        logic [15:0] fn_id;
        logic [31:0] arg;
    } task_t;

    localparam logic [REG_ADDR_W-1:0] TQ_UNTIED_RESERVE = 8'h10;
    localparam logic [REG_ADDR_W-1:0] TER_N_ACK         = 8'h20;
    localparam logic [REG_ADDR_W-1:0] TER_N_NACK        = 8'h24;
    localparam logic [REG_ADDR_W-1:0] TER_CLEAR         = 8'h28;

    typedef enum logic [1:0] {
        TER_IDLE  = 2'd0,
        TER_ALLOC = 2'd1,
        TER_RESP  = 2'd2
    } ter_state_e;

    // Untied tasks must leave `reserve` slots free so tied tasks can always make progress.
    function automatic logic ter_admit(input logic                 tied,
                                       input logic [LOG_TQ_SIZE:0] free,
                                       input logic [LOG_TQ_SIZE:0] reserve);
        return tied ? (free != '0) : (free > reserve);
    endfunction

endpackage

// File: rtl/reg_bus_if.sv
// rtl/reg_bus_if.sv - simple register bus: single-cycle write, read data one cycle after arvalid
interface reg_bus_t;
    import swarm::*;

    logic                  wvalid;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
    logic                  arvalid;
    logic [REG_ADDR_W-1:0] araddr;
    logic                  rvalid;
    logic [REG_DATA_W-1:0] rdata;

    modport slave  (input wvalid, waddr, wdata, arvalid, araddr, output rvalid, rdata);
    modport master (output wvalid, waddr, wdata, arvalid, araddr, input rvalid, rdata);
endinterface

// File: rtl/task_enq_responder.sv
// rtl/task_enq_responder.sv - admits one remote task enqueue at a time and answers with ack/nack
module task_enq_responder
    import swarm::*;
#(
    parameter int TILE_ID    = 0,
    parameter int STAT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic                 s_valid,
    output logic                 s_ready,
    input  task_t                s_data,
    input  logic                 s_tied,
    input  tsb_entry_id_t        s_tsb_id,
    input  tile_id_t             s_src_tile,

    output logic                 tq_alloc_valid,
    input  logic                 tq_alloc_ready,
    output task_t                tq_alloc_data,
    output logic                 tq_alloc_tied,
    input  tq_slot_t             tq_slot,
    input  epoch_t               tq_epoch,
    input  logic [LOG_TQ_SIZE:0] tq_free,

    output logic                 m_resp_valid,
    input  logic                 m_resp_ready,
    output logic                 m_resp_ack,
    output tsb_entry_id_t        m_resp_tsb_id,
    output epoch_t               m_resp_epoch,
    output tq_slot_t             m_resp_tq_slot,
    output tile_id_t             m_resp_dest_tile,
    output tile_id_t             m_resp_src_tile,

    reg_bus_t.slave              reg_bus,

    output logic                 idle
);

    localparam logic [LOG_TQ_SIZE:0] RESERVE_RST = (LOG_TQ_SIZE + 1)'(2);

    ter_state_e              state_q, state_d;
    task_t                   task_q, task_d;
    logic                    tied_q, tied_d;
    tsb_entry_id_t           tsb_id_q, tsb_id_d;
    tile_id_t                src_tile_q, src_tile_d;
    logic                    ack_q, ack_d;
    tq_slot_t                slot_q, slot_d;
    epoch_t                  epoch_q, epoch_d;
    logic [STAT_WIDTH-1:0]   n_ack_q, n_ack_d;
    logic [STAT_WIDTH-1:0]   n_nack_q, n_nack_d;
    logic [LOG_TQ_SIZE:0]    reserve_q, reserve_d;
    logic                    rvalid_q, rvalid_d;
    logic [REG_DATA_W-1:0]   rdata_q, rdata_d;

    logic accept, resp_hs, clear_wr;

    assign s_ready = (state_q == TER_IDLE) || ((state_q == TER_RESP) && m_resp_ready);
    assign accept  = s_valid && s_ready;
    assign resp_hs = (state_q == TER_RESP) && m_resp_ready;
    assign clear_wr = reg_bus.wvalid && (reg_bus.waddr == TER_CLEAR);

    always_comb begin
        state_d    = state_q;
        task_d     = task_q;
        tied_d     = tied_q;
        tsb_id_d   = tsb_id_q;
        src_tile_d = src_tile_q;
        ack_d      = ack_q;
        slot_d     = slot_q;
        epoch_d    = epoch_q;
        n_ack_d    = n_ack_q;
        n_nack_d   = n_nack_q;
        reserve_d  = reserve_q;

        case (state_q)
            TER_ALLOC: begin
                if (tq_alloc_ready) begin
                    slot_d  = tq_slot;
                    epoch_d = tq_epoch;
                    ack_d   = 1'b1;
                    state_d = TER_RESP;
                end
            end
            TER_RESP: begin
                if (m_resp_ready) state_d = TER_IDLE;
            end
            default: ;
        endcase

        // A new request may overwrite the response registers only once the old response is taken.
        if (accept) begin
            task_d     = s_data;
            tied_d     = s_tied;
            tsb_id_d   = s_tsb_id;
            src_tile_d = s_src_tile;
            if (ter_admit(s_tied, tq_free, reserve_q)) begin
                state_d = TER_ALLOC;
            end else begin
                state_d = TER_RESP;
                ack_d   = 1'b0;
                slot_d  = '0;
                epoch_d = '0;
            end
        end

        if (resp_hs) begin
            if (ack_q && (n_ack_q != '1))   n_ack_d  = n_ack_q + 1'b1;
            if (!ack_q && (n_nack_q != '1)) n_nack_d = n_nack_q + 1'b1;
        end
        if (clear_wr) begin
            n_ack_d  = '0;
            n_nack_d = '0;
        end

        if (reg_bus.wvalid && (reg_bus.waddr == TQ_UNTIED_RESERVE)) begin
            reserve_d = (|reg_bus.wdata[REG_DATA_W-1:LOG_TQ_SIZE+1]) ? '1
                                                                     : reg_bus.wdata[LOG_TQ_SIZE:0];
        end
    end

    always_comb begin
        rvalid_d = reg_bus.arvalid;
        rdata_d  = '0;
        if (reg_bus.arvalid) begin
            case (reg_bus.araddr)
                TER_N_ACK:  rdata_d = REG_DATA_W'(n_ack_q);
                TER_N_NACK: rdata_d = REG_DATA_W'(n_nack_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= TER_IDLE;
            task_q     <= '0;
            tied_q     <= 1'b0;
            tsb_id_q   <= '0;
            src_tile_q <= '0;
            ack_q      <= 1'b0;
            slot_q     <= '0;
            epoch_q    <= '0;
            n_ack_q    <= '0;
            n_nack_q   <= '0;
            reserve_q  <= RESERVE_RST;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            task_q     <= task_d;
            tied_q     <= tied_d;
            tsb_id_q   <= tsb_id_d;
            src_tile_q <= src_tile_d;
            ack_q      <= ack_d;
            slot_q     <= slot_d;
            epoch_q    <= epoch_d;
            n_ack_q    <= n_ack_d;
            n_nack_q   <= n_nack_d;
            reserve_q  <= reserve_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign tq_alloc_valid   = (state_q == TER_ALLOC);
    assign tq_alloc_data    = task_q;
    assign tq_alloc_tied    = tied_q;
    assign m_resp_valid     = (state_q == TER_RESP);
    assign m_resp_ack       = ack_q;
    assign m_resp_tsb_id    = tsb_id_q;
    assign m_resp_epoch     = epoch_q;
    assign m_resp_tq_slot   = slot_q;
    assign m_resp_dest_tile = src_tile_q;
    assign m_resp_src_tile  = tile_id_t'(TILE_ID);
    assign reg_bus.rvalid   = rvalid_q;
    assign reg_bus.rdata    = rdata_q;
    assign idle             = (state_q == TER_IDLE);

endmodule

// File: tb/tb_task_enq_responder.sv
// tb/tb_task_enq_responder.sv - scoreboard bench for task_enq_responder
module tb_task_enq_responder;
    import swarm::*;

    localparam int TILE = 7;

    typedef struct {
        logic          ack;
        tsb_entry_id_t tsb;
        epoch_t        epoch;
        tq_slot_t      slot;
        tile_id_t      dest;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic s_valid = 1'b0, s_tied = 1'b0;
    task_t s_data = '0;
    tsb_entry_id_t s_tsb_id = '0;
    tile_id_t s_src_tile = '0;
    logic s_ready;
    logic tq_alloc_valid, tq_alloc_tied;
    logic tq_alloc_ready = 1'b1;
    task_t tq_alloc_data;
    tq_slot_t tq_slot = '0;
    epoch_t tq_epoch = '0;
    logic [LOG_TQ_SIZE:0] tq_free = '0;
    logic m_resp_valid, m_resp_ack, idle;
    logic m_resp_ready = 1'b1;
    tsb_entry_id_t m_resp_tsb_id;
    epoch_t m_resp_epoch;
    tq_slot_t m_resp_tq_slot;
    tile_id_t m_resp_dest_tile, m_resp_src_tile;

    reg_bus_t bus();

    task_enq_responder #(.TILE_ID(TILE), .STAT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tied(s_tied),
        .s_tsb_id(s_tsb_id), .s_src_tile(s_src_tile),
        .tq_alloc_valid(tq_alloc_valid), .tq_alloc_ready(tq_alloc_ready),
        .tq_alloc_data(tq_alloc_data), .tq_alloc_tied(tq_alloc_tied),
        .tq_slot(tq_slot), .tq_epoch(tq_epoch), .tq_free(tq_free),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_ack(m_resp_ack),
        .m_resp_tsb_id(m_resp_tsb_id), .m_resp_epoch(m_resp_epoch),
        .m_resp_tq_slot(m_resp_tq_slot), .m_resp_dest_tile(m_resp_dest_tile),
        .m_resp_src_tile(m_resp_src_tile),
        .reg_bus(bus),
        .idle(idle)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   alloc_seen = 0;
    task_t cur_task;
    logic  cur_tied;
    logic [LOG_TQ_SIZE:0] reserve_m = 2;
    int   exp_ack = 0, exp_nack = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response and allocation monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (tq_alloc_valid) begin
                alloc_seen++;
                if (tq_alloc_ready) begin
                    check_eq("alloc_data", tq_alloc_data, cur_task);
                    check_eq("alloc_tied", tq_alloc_tied, cur_tied);
                end
            end
            if (m_resp_valid && m_resp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("resp_ack", m_resp_ack, e.ack);
                    check_eq("resp_tsb", m_resp_tsb_id, e.tsb);
                    check_eq("resp_epoch", m_resp_epoch, e.epoch);
                    check_eq("resp_slot", m_resp_tq_slot, e.slot);
                    check_eq("resp_dest", m_resp_dest_tile, e.dest);
                    check_eq("resp_src", m_resp_src_tile, TILE);
                end
            end
        end
    end

    function automatic exp_t model(input logic tied, input tsb_entry_id_t tsb,
                                   input tile_id_t src, input logic [LOG_TQ_SIZE:0] free);
        exp_t e;
        e.ack   = tied ? (free >= 1) : (free > reserve_m);
        e.tsb   = tsb;
        e.dest  = src;
        e.slot  = e.ack ? tq_slot : '0;
        e.epoch = e.ack ? tq_epoch : '0;
        return e;
    endfunction

    task automatic drive_req(input logic tied, input tsb_entry_id_t tsb,
                             input tile_id_t src, input logic [LOG_TQ_SIZE:0] free);
        s_valid    = 1'b1;
        s_data     = {32'($urandom), 16'($urandom), 32'($urandom)};
        s_tied     = tied;
        s_tsb_id   = tsb;
        s_src_tile = src;
        tq_free    = free;
    endtask

    task automatic push_exp(input logic tied, input tsb_entry_id_t tsb,
                            input tile_id_t src, input logic [LOG_TQ_SIZE:0] free);
        exp_t e;
        e = model(tied, tsb, src, free);
        sb.push_back(e);
        cur_task = s_data;
        cur_tied = tied;
        if (e.ack) exp_ack++; else exp_nack++;
    endtask

    task automatic send_req(input logic tied, input tsb_entry_id_t tsb,
                            input tile_id_t src, input logic [LOG_TQ_SIZE:0] free);
        int n;
        @(posedge clk); #1;
        drive_req(tied, tsb, src, free);
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        if (!s_ready) check_eq("s_ready_timeout", 0, 1);
        push_exp(tied, tsb, src, free);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic resp_latency(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!m_resp_valid && lat < 20);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !idle) && n < 100) begin @(negedge clk); n++; end
        check_eq("drain", (sb.size() == 0) && idle, 1);
    endtask

    task automatic wait_resp_valid();
        int n;
        n = 0;
        while (!m_resp_valid && n < 20) begin @(negedge clk); n++; end
        check_eq("resp_valid_timeout", m_resp_valid, 1);
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.wvalid = 1'b1; bus.waddr = addr; bus.wdata = data;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        bus.arvalid = 1'b1; bus.araddr = addr;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check_eq("rvalid", bus.rvalid, 1);
        data = bus.rdata;
    endtask

    initial begin
        int lat, a0, bad_ready;
        logic stable;
        logic [31:0] rd;
        logic [63:0] snap;

        bus.wvalid = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.arvalid = 1'b0; bus.araddr = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_resp_valid", m_resp_valid, 0);
        check_eq("rst_alloc_valid", tq_alloc_valid, 0);
        check_eq("rst_rvalid", bus.rvalid, 0);
        rstn = 1'b1;
        reg_read(TER_N_ACK, rd);  check_eq("rst_n_ack", rd, 0);
        reg_read(TER_N_NACK, rd); check_eq("rst_n_nack", rd, 0);

        // Tied accept: response two cycles after the request.
        tq_slot = 4'd6; tq_epoch = 8'h5a;
        send_req(1'b1, 5'd5, 4'd3, 5'd8);
        resp_latency(lat);
        check_eq("ack_latency", lat, 2);
        wait_drain();

        // Untied with free == reserve: nack after one cycle, no allocation.
        a0 = alloc_seen;
        send_req(1'b0, 5'd9, 4'd1, 5'd2);
        resp_latency(lat);
        check_eq("nack_latency", lat, 1);
        wait_drain();
        check_eq("nack_no_alloc", alloc_seen - a0, 0);
        reg_read(TER_N_NACK, rd); check_eq("n_nack_1", rd, 1);

        // One free slot: tied admitted, untied refused.
        tq_slot = 4'd11; tq_epoch = 8'h13;
        send_req(1'b1, 5'd17, 4'd2, 5'd1);
        wait_drain();
        send_req(1'b0, 5'd17, 4'd2, 5'd1);
        wait_drain();

        // Reserve of zero lets an untied task take the last slot.
        reg_write(TQ_UNTIED_RESERVE, 32'd0);
        reserve_m = 0;
        tq_slot = 4'd2; tq_epoch = 8'hc4;
        send_req(1'b0, 5'd30, 4'd9, 5'd1);
        wait_drain();
        reg_write(TQ_UNTIED_RESERVE, 32'd2);
        reserve_m = 2;
        send_req(1'b0, 5'd31, 4'd9, 5'd3);
        wait_drain();
        reg_read(TER_N_ACK, rd);  check_eq("n_ack_mid", rd, exp_ack);
        reg_read(TER_N_NACK, rd); check_eq("n_nack_mid", rd, exp_nack);
        reg_read(8'h44, rd);      check_eq("unmapped_read", rd, 0);

        // Back-pressured response stays frozen and blocks a second request.
        m_resp_ready = 1'b0;
        tq_slot = 4'd14; tq_epoch = 8'h77;
        send_req(1'b1, 5'd12, 4'd5, 5'd8);
        wait_resp_valid();
        snap = {m_resp_ack, m_resp_tsb_id, m_resp_epoch, m_resp_tq_slot, m_resp_dest_tile, m_resp_src_tile};
        @(posedge clk); #1;
        drive_req(1'b0, 5'd13, 4'd6, 5'd8);
        stable = 1'b1; bad_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({m_resp_ack, m_resp_tsb_id, m_resp_epoch, m_resp_tq_slot,
                 m_resp_dest_tile, m_resp_src_tile} !== snap || !m_resp_valid) stable = 1'b0;
            if (s_ready) bad_ready++;
        end
        check_eq("stall_stable", stable, 1);
        check_eq("stall_s_ready_low", bad_ready, 0);
        @(posedge clk); #1;
        m_resp_ready = 1'b1;
        push_exp(1'b0, 5'd13, 4'd6, 5'd8);
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_drain();

        // Counter clear in the same cycle as an ack handshake.
        m_resp_ready = 1'b0;
        send_req(1'b1, 5'd20, 4'd4, 5'd8);
        wait_resp_valid();
        @(posedge clk); #1;
        m_resp_ready = 1'b1;
        bus.wvalid = 1'b1; bus.waddr = TER_CLEAR; bus.wdata = '0;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        exp_ack = 0; exp_nack = 0;
        wait_drain();
        reg_read(TER_N_ACK, rd);  check_eq("clear_n_ack", rd, 0);
        reg_read(TER_N_NACK, rd); check_eq("clear_n_nack", rd, 0);

        // Reset while waiting on the TQ drops the request silently.
        tq_alloc_ready = 1'b0;
        send_req(1'b1, 5'd25, 4'd8, 5'd8);
        begin
            int n;
            n = 0;
            while (!tq_alloc_valid && n < 20) begin @(negedge clk); n++; end
            check_eq("reach_alloc", tq_alloc_valid, 1);
        end
        rstn = 1'b0;
        #1;
        void'(sb.pop_back());
        exp_ack = 0; exp_nack = 0; reserve_m = 2;
        check_eq("mid_rst_idle", idle, 1);
        check_eq("mid_rst_resp_valid", m_resp_valid, 0);
        check_eq("mid_rst_alloc_valid", tq_alloc_valid, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        tq_alloc_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("post_rst_no_resp", m_resp_valid, 0);
        tq_slot = 4'd9; tq_epoch = 8'h3c;
        send_req(1'b1, 5'd26, 4'd10, 5'd8);
        resp_latency(lat);
        check_eq("post_rst_latency", lat, 2);
        wait_drain();
        reg_read(TER_N_ACK, rd); check_eq("post_rst_n_ack", rd, exp_ack);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
